// File: rtl/mips_mon_pkg.sv
// Shared definitions for the MIPS store-result monitor: state encoding and
// the default pass/ignore store addresses used by both the FPGA top and benches.
package mips_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_t;

  localparam logic [31:0] DEF_PASS_ADDR      = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA      = 32'd7;
  localparam logic [31:0] DEF_IGNORE_ADDR    = 32'd80;
  localparam int          DEF_TIMEOUT_CYCLES = 1000;
  localparam int          DEF_CNT_W          = 16;

  // A store verdict outranks the timeout check taken on the same edge.
  function automatic mon_state_t next_run_state(input logic i_memwrite,
                                                input logic i_pass_hit,
                                                input logic i_ignore_hit,
                                                input logic i_at_limit);
    mon_state_t v_state;
    if (i_memwrite && i_pass_hit) begin
      v_state = ST_PASS;
    end else if (i_memwrite && !i_ignore_hit) begin
      v_state = ST_FAIL;
    end else if (i_at_limit) begin
      v_state = ST_TIMEOUT;
    end else begin
      v_state = ST_RUN;
    end
    return v_state;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; async reset, synchronous clear, enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/store_result_monitor.sv
// Watches the MIPS data-memory write bus and reaches a sticky pass/fail/timeout
// verdict, latching the first illegal store and requesting a core halt.
module store_result_monitor
  import mips_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] IGNORE_ADDR    = DEF_IGNORE_ADDR,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int          CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             halt,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  mon_state_t       r_state;
  mon_state_t       w_next_state;
  logic [31:0]      r_fail_addr;
  logic [31:0]      r_fail_data;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_store_cnt;
  logic             w_run;
  logic             w_pass_hit;
  logic             w_ignore_hit;
  logic             w_at_limit;

  assign w_run        = (r_state == ST_RUN);
  assign w_pass_hit   = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign w_ignore_hit = (dataadr == IGNORE_ADDR);
  // Compare at 32 bits so a narrow counter cannot alias onto the limit.
  assign w_at_limit   = (32'(w_cycle_cnt) == 32'(TIMEOUT_CYCLES - 1));
  assign w_next_state = next_run_state(memwrite, w_pass_hit, w_ignore_hit, w_at_limit);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_run),
    .i_clr   (1'b0),
    .o_count (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_run && memwrite),
    .i_clr   (1'b0),
    .o_count (w_store_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_fail_addr <= 32'd0;
      r_fail_data <= 32'd0;
    end else if (w_run) begin
      r_state <= w_next_state;
      if (w_next_state == ST_FAIL) begin
        r_fail_addr <= dataadr;
        r_fail_data <= writedata;
      end
    end
  end

  assign done        = !w_run;
  assign halt        = !w_run;
  assign pass        = (r_state == ST_PASS);
  assign fail        = (r_state == ST_FAIL);
  assign timeout     = (r_state == ST_TIMEOUT);
  assign store_count = w_store_cnt;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_store_result_monitor.sv
// Directed bench for store_result_monitor: pass, fail, timeout, async reset
// and store-counter saturation, with hand-computed expectations.
module tb_store_result_monitor;
  import mips_mon_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;

  logic        done, pass, fail, timeout, halt;
  logic [15:0] store_count;
  logic [31:0] fail_addr, fail_data;

  logic        s_done, s_pass, s_fail, s_timeout, s_halt;
  logic [3:0]  s_store_count;
  logic [31:0] s_fail_addr, s_fail_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_result_monitor #(.TIMEOUT_CYCLES(20), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .halt(halt), .store_count(store_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  store_result_monitor #(.TIMEOUT_CYCLES(1000), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(s_done), .pass(s_pass), .fail(s_fail),
    .timeout(s_timeout), .halt(s_halt), .store_count(s_store_count),
    .fail_addr(s_fail_addr), .fail_data(s_fail_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge (or at time 0); returns on the negedge after one post-reset edge.
  task automatic do_reset();
    reset = 1'b1;
    memwrite = 1'b0;
    #20;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_store_count", {16'd0, store_count}, 32'd0);
    chk("rst_fail_addr", fail_addr, 32'd0);
    chk("rst_fail_data", fail_data, 32'd0);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr = a;
    writedata = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  initial begin
    // Pass sequence
    do_reset();
    store(32'd80, 32'd10);
    chk("p_ignore_pass", {31'd0, pass}, 32'd0);
    chk("p_ignore_halt", {31'd0, halt}, 32'd0);
    chk("p_ignore_count", {16'd0, store_count}, 32'd1);
    store(32'd84, 32'd7);
    chk("p_pass", {31'd0, pass}, 32'd1);
    chk("p_fail", {31'd0, fail}, 32'd0);
    chk("p_done", {31'd0, done}, 32'd1);
    chk("p_halt", {31'd0, halt}, 32'd1);
    chk("p_timeout", {31'd0, timeout}, 32'd0);
    chk("p_count", {16'd0, store_count}, 32'd2);
    chk("p_fail_addr", fail_addr, 32'd0);

    // Asynchronous reset from PASS, then rerun
    #3;
    reset = 1'b1;
    #1;
    chk("ar_pass", {31'd0, pass}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_count", {16'd0, store_count}, 32'd0);
    @(negedge clk);
    do_reset();
    store(32'd84, 32'd7);
    chk("rerun_pass", {31'd0, pass}, 32'd1);
    chk("rerun_count", {16'd0, store_count}, 32'd1);

    // Fail on illegal address, later stores ignored
    @(negedge clk);
    do_reset();
    store(32'd80, 32'd10);
    store(32'd60, 32'd3);
    chk("f_fail", {31'd0, fail}, 32'd1);
    chk("f_pass", {31'd0, pass}, 32'd0);
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_addr", fail_addr, 32'd60);
    chk("f_data", fail_data, 32'd3);
    chk("f_count", {16'd0, store_count}, 32'd2);
    store(32'd84, 32'd7);
    chk("f_after_pass", {31'd0, pass}, 32'd0);
    chk("f_after_fail", {31'd0, fail}, 32'd1);
    chk("f_after_count", {16'd0, store_count}, 32'd2);
    chk("f_after_addr", fail_addr, 32'd60);

    // Pass address with wrong data
    @(negedge clk);
    do_reset();
    store(32'd84, 32'd8);
    chk("wd_fail", {31'd0, fail}, 32'd1);
    chk("wd_pass", {31'd0, pass}, 32'd0);
    chk("wd_addr", fail_addr, 32'd84);
    chk("wd_data", fail_data, 32'd8);
    chk("wd_count", {16'd0, store_count}, 32'd1);

    // Full 32-bit compare: high data bit set
    @(negedge clk);
    do_reset();
    store(32'd84, 32'h8000_0007);
    chk("hi_data_fail", {31'd0, fail}, 32'd1);
    chk("hi_data_val", fail_data, 32'h8000_0007);

    // Full 32-bit compare: high address bit set on the ignore address
    @(negedge clk);
    do_reset();
    store(32'h0001_0050, 32'd10);
    chk("hi_addr_fail", {31'd0, fail}, 32'd1);
    chk("hi_addr_val", fail_addr, 32'h0001_0050);

    // Timeout after exactly 20 edges in RUN
    @(negedge clk);
    do_reset();
    repeat (18) @(negedge clk);
    chk("to_before", {31'd0, timeout}, 32'd0);
    chk("to_before_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_halt", {31'd0, halt}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_fail", {31'd0, fail}, 32'd0);
    store(32'd84, 32'd7);
    chk("to_sticky_pass", {31'd0, pass}, 32'd0);
    chk("to_sticky_count", {16'd0, store_count}, 32'd0);

    // Store verdict wins over timeout on the last edge
    @(negedge clk);
    do_reset();
    repeat (18) @(negedge clk);
    store(32'd84, 32'd7);
    chk("race_pass", {31'd0, pass}, 32'd1);
    chk("race_timeout", {31'd0, timeout}, 32'd0);
    chk("race_count", {16'd0, store_count}, 32'd1);

    // 4-bit store counter saturation
    @(negedge clk);
    do_reset();
    repeat (14) store(32'd80, 32'd10);
    chk("sat_14", {28'd0, s_store_count}, 32'd14);
    repeat (6) store(32'd80, 32'd10);
    chk("sat_15", {28'd0, s_store_count}, 32'd15);
    chk("sat_done", {31'd0, s_done}, 32'd0);
    chk("sat_halt", {31'd0, s_halt}, 32'd0);
    chk("sat_pass", {31'd0, s_pass}, 32'd0);
    chk("sat_fail", {31'd0, s_fail}, 32'd0);
    chk("sat_timeout", {31'd0, s_timeout}, 32'd0);
    chk("sat_fail_addr", s_fail_addr, 32'd0);
    chk("sat_fail_data", s_fail_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_result_monitor.md
Name: store_result_monitor

Overview:
- Synthesizable self-check stage downstream of the single-cycle MIPS `top`.
- Consumes the data-memory write bus (`memwrite`, `dataadr`, `writedata`) and decides pass, fail or timeout in hardware.
- Lets the FPGA build report test-program results on LEDs without a simulator.
- Latches the first offending store and drives `halt` so the core can be frozen.

Parameters:
- PASS_ADDR, 84, store address that ends the test when paired with PASS_DATA.
- PASS_DATA, 7, required write data at PASS_ADDR for a pass.
- IGNORE_ADDR, 80, store address that is always legal and never ends the test.
- TIMEOUT_CYCLES, 1000, cycles after reset release with no verdict before timeout.
- CNT_W, 16, width of the cycle and store counters; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  core data-memory write strobe.
- dataadr  input  32  core data-memory address.
- writedata  input  32  core data-memory write data.
- done  output  1  verdict reached (any of pass/fail/timeout).
- pass  output  1  PASS_ADDR/PASS_DATA store seen.
- fail  output  1  illegal store seen.
- timeout  output  1  no verdict within TIMEOUT_CYCLES.
- halt  output  1  request to the core to stop; equals done.
- store_count  output  CNT_W  number of stores accepted while RUN, including the terminating store.
- fail_addr  output  32  dataadr of the offending store; 0 unless fail.
- fail_data  output  32  writedata of the offending store; 0 unless fail.

Behaviour:
- Reset (asynchronous, active-high) forces state RUN, the cycle counter to 0, and every output to 0.
- Reset asserted mid-operation or after a verdict clears everything immediately, including a sticky verdict.
- States:
  - RUN: evaluate the store bus each rising edge.
  - PASS, FAIL, TIMEOUT: terminal, sticky until reset.
- RUN evaluation, in priority order, each edge:
  - memwrite=1, dataadr==PASS_ADDR, writedata==PASS_DATA -> PASS.
  - memwrite=1, dataadr==IGNORE_ADDR -> stay RUN.
  - memwrite=1, any other address or data (including PASS_ADDR with wrong data) -> FAIL; latch fail_addr and fail_data.
  - memwrite=0 -> stay RUN.
  - Then, if the cycle counter == TIMEOUT_CYCLES-1 and no store verdict was taken this edge -> TIMEOUT. A store verdict on the same edge wins.
- Counters:
  - Cycle counter increments every edge in RUN, freezes in terminal states.
  - store_count increments on every memwrite=1 edge in RUN, saturates at all-ones, freezes in terminal states.
- Latency:
  - Verdict outputs are registered.
  - done/pass/fail/timeout/halt rise in the cycle after the sampling edge, i.e. 1 cycle after the store cycle.
  - store_count reflects a store from the next cycle on.
- Output encoding:
  - pass, fail and timeout are mutually exclusive, one-hot with done.
  - Outputs are decoded from the state register; no combinational path from inputs to outputs.
- Stores in terminal states are ignored: no counter change, no re-latch.
- All comparisons are full 32-bit equality; no masking of the low address bits.

Decomposition:
- Shared package `mips_mon_pkg`:
  - 2-bit state encoding: RUN=0, PASS=1, FAIL=2, TIMEOUT=3.
  - Default PASS_ADDR, PASS_DATA and IGNORE_ADDR constants, so the testbench and FPGA top share one definition.
- One sub-module, `sat_counter` (width param, enable, synchronous clear, asynchronous reset), instanced twice: cycle counter and store counter.

Test Plan:
- Reset held 22 ns, then stores (80,10), (84,7) -> pass=1, fail=0, store_count=2, halt=1 one cycle after the 84 store.
- Stores (80,10), (60,3) -> fail=1, fail_addr=60, fail_data=3, store_count=2, later store (84,7) ignored.
- Store (84,8) -> fail=1, fail_addr=84, fail_data=8, pass=0.
- No stores; TIMEOUT_CYCLES=20 -> timeout=1 after exactly 20 cycles post-reset; store (84,7) on cycle 19 gives pass=1 instead, timeout=0.
- In PASS, assert reset mid-cycle -> all outputs 0 asynchronously, counters 0; rerun (84,7) -> pass again.
- CNT_W=4, 20 stores to 80 with large TIMEOUT -> store_count saturates at 15, state stays RUN.
